// File: rtl/spi_master_byte.sv
// spi_master_byte: SPI mode 0 byte master (CPOL=0, CPHA=0, MSB first).
// Drives SCLK, active-low _CS and MOSI from CLK, and captures MISO into RxData.
// Optional feature: define SPI_MASTER_CS_GAP_EN to insert a 2*CLK_DIV-cycle
// busy gap after every _CS rise.
module spi_master_byte #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       Stop,
    input  logic       HoldCS,
    input  logic [7:0] TxData,
    input  logic       MISO,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] RxData,
    output logic       SCLK,
    output logic       MOSI,
    output logic       _CS
);

    localparam int unsigned CntW = $clog2(CLK_DIV + 1);
    localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StFinish,
        StHold
`ifdef SPI_MASTER_CS_GAP_EN
        , StGap
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      rx_q, rx_d;
    logic            hold_q, hold_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            cs_n_q, cs_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cnt_zero;
`ifdef SPI_MASTER_CS_GAP_EN
    // Gap spans two divide periods; this flag marks the second one.
    logic            gap_half_q, gap_half_d;
`endif

    assign cnt_zero = (cnt_q == '0);

    // Next-state and next-output logic; all outputs are registered so SCLK cannot glitch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        hold_d  = hold_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
        gap_half_d = gap_half_q;
`endif
        case (state_q)
            StIdle, StHold: begin
                if (Start) begin
                    state_d = StSetup;
                    cnt_d   = Reload;
                    bit_d   = 3'd0;
                    tx_d    = TxData;
                    hold_d  = HoldCS;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = TxData[7];
                    busy_d  = 1'b1;
                end else if (state_q == StHold && Stop) begin
                    cs_n_d = 1'b1;
                    mosi_d = 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
                    state_d    = StGap;
                    cnt_d      = Reload;
                    gap_half_d = 1'b0;
                    busy_d     = 1'b1;
`else
                    state_d = StIdle;
`endif
                end
            end
            StSetup, StLow: begin
                if (cnt_zero) begin
                    // Rising SCLK edge: sample MISO on the same clock edge.
                    state_d = StHigh;
                    cnt_d   = Reload;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], MISO};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHigh: begin
                if (cnt_zero) begin
                    bit_d  = bit_q + 3'd1;
                    sclk_d = 1'b0;
                    cnt_d  = Reload;
                    if (bit_q == 3'd7) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StLow;
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFinish: begin
                if (cnt_zero) begin
                    done_d = 1'b1;
                    rx_d   = rx_sh_q;
                    if (hold_q) begin
                        state_d = StHold;
                        busy_d  = 1'b0;
                    end else begin
                        cs_n_d = 1'b1;
                        mosi_d = 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
                        state_d    = StGap;
                        cnt_d      = Reload;
                        gap_half_d = 1'b0;
`else
                        state_d = StIdle;
                        busy_d  = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef SPI_MASTER_CS_GAP_EN
            StGap: begin
                if (cnt_zero) begin
                    cnt_d = Reload;
                    if (gap_half_q) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        gap_half_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 8'h00;
            rx_sh_q <= 8'h00;
            rx_q    <= 8'h00;
            hold_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
            gap_half_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            hold_q  <= hold_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPI_MASTER_CS_GAP_EN
            gap_half_q <= gap_half_d;
`endif
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign RxData = rx_q;
    assign SCLK   = sclk_q;
    assign MOSI   = mosi_q;
    assign _CS    = cs_n_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Testbench for spi_master_byte: vector table plus scoreboard, with a
// peripheral model that shifts a byte out on MISO and an edge-timing monitor.
module tb_spi_master_byte;

    localparam int unsigned D = 2;
`ifdef SPI_MASTER_CS_GAP_EN
    localparam bit GapEn = 1'b1;
`else
    localparam bit GapEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       hold_cs = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso;
    logic       busy, done, sclk, mosi, cs_n;
    logic [7:0] rx_data;

    spi_master_byte #(.CLK_DIV(D)) dut (
        .CLK    (clk),
        .RST    (rst),
        .Start  (start),
        .Stop   (stop),
        .HoldCS (hold_cs),
        .TxData (tx_data),
        .MISO   (miso),
        .Busy   (busy),
        .Done   (done),
        .RxData (rx_data),
        .SCLK   (sclk),
        .MOSI   (mosi),
        ._CS    (cs_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] periph;
        logic       hold;
        logic       stp;
        logic [7:0] exp_rx;
        logic       exp_cs;
    } vec_t;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        logic       cs;
    } sb_t;

    sb_t        sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         e0 = 0;
    int         done_count = 0;
    int         cs_rises = 0;
    logic [3:0] rises = 4'd0;
    logic [7:0] mosi_sh = 8'h00;
    logic [7:0] periph_byte = 8'h00;
    logic       mon_en = 1'b1;
    logic       prev_sclk = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_cs = 1'b1;

    // Peripheral model: presents the next MSB-first bit, updated right after each rise.
    assign miso = periph_byte[3'd7 - rises[2:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: edge timing against e0, MOSI capture, Done scoreboard.
    always @(posedge clk) begin
        sb_t s;
        #1;
        if (rst) begin
            rises   = 4'd0;
            mosi_sh = 8'h00;
        end else if (mon_en) begin
            if (sclk && !prev_sclk) begin
                chk("rise_time", cyc - e0, int'(D) * (1 + 2 * int'(rises)));
                mosi_sh = {mosi_sh[6:0], mosi};
                rises   = rises + 4'd1;
            end
            if (!sclk && prev_sclk)
                chk("fall_time", cyc - e0, 2 * int'(D) * int'(rises));
            if (cs_n && !prev_cs) cs_rises++;
            if (prev_done) chk("done_width", done, 0);
            if (done) begin
                done_count++;
                chk("done_time", cyc - e0, 17 * int'(D));
                chk("sclk_rises", rises, 8);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    s = sb_q.pop_front();
                    chk("rx_data", rx_data, s.rx);
                    chk("mosi_byte", mosi_sh, s.tx);
                    chk("cs_at_done", cs_n, s.cs);
                    chk("busy_at_done", busy, (GapEn && s.cs) ? 1 : 0);
                end
                rises = 4'd0;
            end
        end
        prev_sclk = sclk;
        prev_done = done;
        prev_cs   = cs_n;
    end

    task automatic send(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100 * D) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_start", busy, 0);
        tx_data     = v.tx;
        hold_cs     = v.hold;
        stop        = v.stp;
        start       = 1'b1;
        periph_byte = v.periph;
        e0          = cyc + 1;
        sb_q.push_back('{tx: v.tx, rx: v.exp_rx, cs: v.exp_cs});
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 40 * D + 10) begin
            @(negedge clk);
            n++;
        end
        chk("done_count", done_count, target);
    endtask

    task automatic reset_and_check(input string name);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk({name, "_cs"}, cs_n, 1);
        chk({name, "_sclk"}, sclk, 0);
        chk({name, "_mosi"}, mosi, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_rx"}, rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t v;
    int   dc;
    int   cr0;
    int   exp_rises;
    int   gap_busy;
    int   n;

    initial begin
        vecs[0] = '{tx: 8'hA5, periph: 8'h3C, hold: 1'b0, stp: 1'b0, exp_rx: 8'h3C, exp_cs: 1'b1};
        vecs[1] = '{tx: 8'h12, periph: 8'h5A, hold: 1'b1, stp: 1'b0, exp_rx: 8'h5A, exp_cs: 1'b0};
        vecs[2] = '{tx: 8'h34, periph: 8'hC3, hold: 1'b1, stp: 1'b0, exp_rx: 8'hC3, exp_cs: 1'b0};
        // Start and Stop together from HOLD: Start wins.
        vecs[3] = '{tx: 8'h7E, periph: 8'h81, hold: 1'b0, stp: 1'b1, exp_rx: 8'h81, exp_cs: 1'b1};
        vecs[4] = '{tx: 8'h00, periph: 8'hFF, hold: 1'b0, stp: 1'b0, exp_rx: 8'hFF, exp_cs: 1'b1};
        vecs[5] = '{tx: 8'hFF, periph: 8'h00, hold: 1'b0, stp: 1'b0, exp_rx: 8'h00, exp_cs: 1'b1};

        reset_and_check("reset_init");

        cr0 = cs_rises;
        exp_rises = 0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i]);
            wait_done(done_count + 1);
            if (!vecs[i].hold) exp_rises++;
        end
        chk("cs_rise_count", cs_rises - cr0, exp_rises);

        // Hold then release with Stop.
        v = '{tx: 8'hC3, periph: 8'h96, hold: 1'b1, stp: 1'b0, exp_rx: 8'h96, exp_cs: 1'b0};
        send(v);
        wait_done(done_count + 1);
        repeat (3) @(negedge clk);
        chk("hold_cs_low", cs_n, 0);
        chk("hold_sclk_low", sclk, 0);
        chk("hold_busy", busy, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_cs_rise", cs_n, 1);
        chk("stop_busy", busy, GapEn ? 1 : 0);

        // Start while busy is ignored.
        v = '{tx: 8'h00, periph: 8'hA5, hold: 1'b0, stp: 1'b0, exp_rx: 8'hA5, exp_cs: 1'b1};
        send(v);
        while (cyc < e0 + 5 * int'(D)) @(negedge clk);
        tx_data = 8'hFF;
        hold_cs = 1'b1;
        start   = 1'b1;
        repeat (3) @(negedge clk);
        start   = 1'b0;
        hold_cs = 1'b0;
        wait_done(done_count + 1);
        dc = done_count;
        repeat (25 * D) @(negedge clk);
        chk("busy_start_one_done", done_count, dc);

        // Reset at bit 4 of 0xF0: no Done, then a clean 0x81 byte.
        v = '{tx: 8'hF0, periph: 8'h55, hold: 1'b0, stp: 1'b0, exp_rx: 8'h55, exp_cs: 1'b1};
        send(v);
        n = 0;
        while (cyc < e0 + 9 * int'(D) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_byte_rises", rises, 5);
        dc = done_count;
        sb_q.delete();
        reset_and_check("reset_mid");
        repeat (20 * D) @(negedge clk);
        chk("no_done_after_reset", done_count, dc);
        v = '{tx: 8'h81, periph: 8'h6B, hold: 1'b0, stp: 1'b0, exp_rx: 8'h6B, exp_cs: 1'b1};
        send(v);
        wait_done(dc + 1);
        chk("sb_empty", sb_q.size(), 0);

`ifdef SPI_MASTER_CS_GAP_EN
        // Start held high: count busy gap cycles between frames.
        mon_en  = 1'b0;
        tx_data = 8'h5A;
        start   = 1'b1;
        n = 0;
        while (!done && n < 60 * D) begin
            @(negedge clk);
            n++;
        end
        chk("gap_first_done", done, 1);
        gap_busy = 0;
        n = 0;
        while (cs_n && n < 10 * D) begin
            if (busy) gap_busy++;
            @(negedge clk);
            n++;
        end
        chk("gap_cs_relow", cs_n, 0);
        chk("gap_busy_cycles", gap_busy, 2 * D);
        start = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
